// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, MMIO register
// offsets, FSM states and the byte-lane helpers used by the store path.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    localparam logic [31:0] LED_OFFSET = 32'h0000_0000;
    localparam logic [31:0] CNT_OFFSET = 32'h0000_0004;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        RGN_NONE,
        RGN_RAM,
        RGN_LED,
        RGN_CNT
    } region_e;

    // Everything the response cycle needs, captured at the acceptance edge.
    typedef struct packed {
        logic        err;
        logic        from_ram;
        logic [31:0] data;
    } resp_t;

    function automatic logic misaligned(input size_e size, input logic [1:0] lo);
        return (size == SIZE_HALF && lo[0]) || (size == SIZE_WORD && lo != 2'b00);
    endfunction

    function automatic logic [3:0] byte_enables(input size_e size, input logic [1:0] lo);
        case (size)
            SIZE_BYTE: return 4'b0001 << lo;
            SIZE_HALF: return 4'b0011 << lo;
            SIZE_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    // Right-aligned store data moved up into the lane addressed by addr[1:0].
    function automatic logic [31:0] lane_align(input logic [31:0] wdata, input logic [1:0] lo);
        return wdata << {lo, 3'b000};
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-bus bundle: request side driven by the CPU, response side by the
// memory responder.
interface data_mem_responder_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output req, we, addr, wdata, size,
        input  rdata, ready, err
    );

    modport slave (
        input  req, we, addr, wdata, size,
        output rdata, ready, err
    );

endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port;
// a write and a read of the same word in one cycle returns the old contents.
module dmem_ram #(
    parameter  int DEPTH_WORDS = 256,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset branch so it maps onto RAM macros/LUT-RAM;
    // a reset loop over every word would force it into discrete flops.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder: decodes each CPU access into RAM, LED register or
// cycle counter, applies stores at acceptance and answers one cycle later.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_2000
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    output logic [7:0]           leds
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    state_e      state;
    state_e      state_nxt;
    logic        accept;
    size_e       size;
    region_e     region;
    logic        fault;
    logic        ram_en;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        led_wr;
    logic        cnt_wr;
    logic [31:0] counter;
    logic [31:0] resp_data_nxt;
    resp_t       resp;

    assign size = size_e'(bus.size);

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        region = RGN_NONE;
        if (bus.addr < RAM_BYTES) begin
            region = RGN_RAM;
        end else if (bus.addr == MMIO_BASE + LED_OFFSET) begin
            region = RGN_LED;
        end else if (bus.addr == MMIO_BASE + CNT_OFFSET) begin
            region = RGN_CNT;
        end

        // The counter only accepts whole-word stores; narrower ones fault.
        fault = (size == SIZE_RSVD)
             || misaligned(size, bus.addr[1:0])
             || (region == RGN_NONE)
             || (region == RGN_CNT && bus.we && size != SIZE_WORD);
    end

    // NOTE: state-holding processes use non-blocking assignments only, so all
    // registers sample their inputs from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    accept    = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ram_en    = accept && (region == RGN_RAM) && !fault;
    assign ram_be    = (ram_en && bus.we) ? byte_enables(size, bus.addr[1:0]) : 4'b0000;
    assign ram_wdata = lane_align(bus.wdata, bus.addr[1:0]);
    assign led_wr    = accept && bus.we && (region == RGN_LED) && !fault;
    assign cnt_wr    = accept && bus.we && (region == RGN_CNT) && !fault;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .be    (ram_be),
        .addr  (bus.addr[AW+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds <= 8'h00;
        end else if (led_wr) begin
            leds <= bus.wdata[7:0];
        end
    end

    // A software write wins over the free-running increment in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter <= 32'h0000_0000;
        end else if (cnt_wr) begin
            counter <= bus.wdata;
        end else begin
            counter <= counter + 32'd1;
        end
    end

    // Register-sourced load data is the value seen just before the acceptance edge.
    always_comb begin
        resp_data_nxt = 32'h0000_0000;
        if (!fault && !bus.we) begin
            case (region)
                RGN_LED: resp_data_nxt = {24'h00_0000, leds};
                RGN_CNT: resp_data_nxt = counter;
                default: resp_data_nxt = 32'h0000_0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp <= '0;
        end else if (accept) begin
            resp.err      <= fault;
            resp.from_ram <= !fault && !bus.we && (region == RGN_RAM);
            resp.data     <= resp_data_nxt;
        end
    end

    // Response outputs are gated by the state so they read zero outside RESP.
    always_comb begin
        bus.ready = (state == ST_RESP);
        bus.err   = (state == ST_RESP) && resp.err;
        bus.rdata = 32'h0000_0000;
        if (state == ST_RESP) begin
            bus.rdata = resp.from_ram ? ram_rdata : resp.data;
        end
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The parameter list SHALL be: DEPTH_WORDS, 256, RAM size in 32-bit words (power of two, at most 2048).
REQ-002 The parameter list SHALL be: MMIO_BASE, 32'h0000_2000, base address of the peripheral window.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The port list SHALL be, in order:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  1  access request from the CPU
- we  in  1  1 = store, 0 = load
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- size  in  2  00 byte, 01 half, 10 word, 11 reserved
- rdata  out  32  load data
- ready  out  1  one-cycle response strobe
- err  out  1  access fault, valid with ready
- leds  out  8  LED register

Function
REQ-005 The FSM SHALL have two states, IDLE and RESP.
REQ-006 In IDLE with req=1, the request SHALL be accepted; we, addr, wdata and size are sampled at that edge, and the state moves to RESP.
REQ-007 In RESP, ready SHALL be 1 for exactly one cycle, then the state returns to IDLE; req is ignored in RESP.
REQ-008 Load latency SHALL be one cycle: rdata and err are valid in the cycle after acceptance, and maximum throughput is one access per two cycles.
REQ-009 Outside RESP, rdata SHALL be 0 and err SHALL be 0.
REQ-010 Address map:
- RAM: 0 to DEPTH_WORDS*4-1.
- LED register: MMIO_BASE+0.
- Cycle counter: MMIO_BASE+4.
- Any other address SHALL be unmapped.
REQ-011 An access SHALL be misaligned if size=01 with addr[0]=1, or size=10 with addr[1:0]!=0; size=11 SHALL be illegal.
REQ-012 A misaligned, illegal or unmapped access SHALL give err=1 and rdata=0, and SHALL change no state.
REQ-013 A RAM store SHALL shift wdata into the lane selected by addr[1:0] and write only the byte enables for that size; the other bytes of the word SHALL be unchanged.
REQ-014 A RAM load SHALL return the full aligned 32-bit word; lane extraction and sign extension are done in the CPU.
REQ-015 LED register:
- A store of any legal size SHALL write wdata[7:0].
- A load SHALL return {24'b0, leds}.
REQ-016 Cycle counter:
- It SHALL increment by 1 every cycle and wrap from FFFF_FFFF to 0.
- A word store SHALL load wdata, taking priority over the increment in that cycle.
- A byte or half store to it SHALL give err=1 and SHALL NOT change the counter.
- A load SHALL return the counter value at the acceptance edge.
REQ-017 A store response SHALL return rdata=0.
REQ-018 The store side effect SHALL take place at the acceptance edge, so that a load accepted next returns the new data.

Reset
REQ-019 When reset=0, the block SHALL set, immediately: state=IDLE, ready=0, err=0, rdata=0, leds=0, counter=0.
REQ-020 A reset during RESP SHALL abort the response, with no ready pulse after reset is released.
REQ-021 RAM contents SHALL NOT be reset.

Structure
REQ-022 A shared package SHALL hold the size encodings, the LED and counter offsets, and the FSM state encoding.
REQ-023 The RAM SHALL be one sub-module, dmem_ram: a single-port RAM with a 4-bit byte-enable write and a registered word read.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Word store 0xDEADBEEF to 0x10, then word load from 0x10 -> ready one cycle after each acceptance, rdata=0xDEADBEEF, err=0.
- Byte store 0xAB to 0x13 over 0x11223344, then word load -> rdata=0xAB223344.
- Half store to 0x11 -> err=1, rdata=0; a following load of 0x10 is unchanged.
- Load from 0x0000_3000 -> err=1, rdata=0, leds unchanged.
- Word store 0xFFFF_FFFE to MMIO_BASE+4, then a load 2 cycles later -> value has wrapped to 0 (exact value checked against the cycle count).
- LED store 0x1A5 -> leds=0xA5; assert reset during the following load's RESP -> ready never pulses, leds=0.
